// File: rtl/axi_slave_write_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : axi_slave_write_ctrl
// Description : Slave-side AXI write responder. It takes one AW burst, turns
//               each W beat into a word write on an SRAM port, then returns B.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_slave_write_ctrl #(
    parameter int IDS_W  = 8,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 4,
    parameter int MEM_AW = 14
) (
    input  logic                ACLK,
    input  logic                ARESETn,
    input  logic [IDS_W-1:0]    AWID,
    input  logic [ADDR_W-1:0]   AWADDR,
    input  logic [LEN_W-1:0]    AWLEN,
    input  logic [2:0]          AWSIZE,
    input  logic [1:0]          AWBURST,
    input  logic                AWVALID,
    output logic                AWREADY,
    input  logic [DATA_W-1:0]   WDATA,
    input  logic [DATA_W/8-1:0] WSTRB,
    input  logic                WLAST,
    input  logic                WVALID,
    output logic                WREADY,
    output logic [IDS_W-1:0]    BID,
    output logic [1:0]          BRESP,
    output logic                BVALID,
    input  logic                BREADY,
    output logic                mem_we,
    output logic [MEM_AW-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_bwe
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [2:0] SIZE_4B     = 3'b010;
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;

    state_t              state_q, state_d;
    logic [IDS_W-1:0]    id_q,    id_d;
    logic [MEM_AW-1:0]   addr_q,  addr_d;
    logic [LEN_W-1:0]    len_q,   len_d;
    logic                incr_q,  incr_d;
    logic [LEN_W-1:0]    cnt_q,   cnt_d;
    logic                err_q,   err_d;

    logic                w_beat;
    logic                w_last_cnt;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q <= ST_IDLE;
            id_q    <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            incr_q  <= 1'b0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            incr_q  <= incr_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Handshake readiness is decoded from state so reset drops it asynchronously.
    assign AWREADY    = (state_q == ST_IDLE);
    assign WREADY     = (state_q == ST_DATA);
    assign BVALID     = (state_q == ST_RESP);
    assign BID        = id_q;
    assign BRESP      = (BVALID && err_q) ? 2'b10 : 2'b00;
    assign w_beat     = WVALID && WREADY;
    assign w_last_cnt = (cnt_q == len_q);

    // Writes use the error state as of the start of the beat; a WLAST mismatch
    // only suppresses the beats that follow it.
    assign mem_we    = w_beat && !err_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = WDATA;
    assign mem_bwe   = mem_we ? WSTRB : '0;

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        addr_d  = addr_q;
        len_d   = len_q;
        incr_d  = incr_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        unique case (state_q)
            ST_IDLE: begin
                if (AWVALID) begin
                    state_d = ST_DATA;
                    id_d    = AWID;
                    addr_d  = AWADDR[MEM_AW+1:2];
                    len_d   = AWLEN;
                    incr_d  = (AWBURST == BURST_INCR);
                    cnt_d   = '0;
                    err_d   = (AWSIZE != SIZE_4B) ||
                              ((AWBURST != BURST_FIXED) && (AWBURST != BURST_INCR));
                end
            end
            ST_DATA: begin
                if (w_beat) begin
                    cnt_d = cnt_q + 1'b1;
                    if (incr_q) begin
                        addr_d = addr_q + 1'b1;
                    end
                    if (WLAST != w_last_cnt) begin
                        err_d = 1'b1;
                    end
                    if (w_last_cnt) begin
                        state_d = ST_RESP;
                    end
                end
            end
            ST_RESP: begin
                if (BREADY) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_axi_slave_write_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_slave_write_ctrl
// Description : Directed self-checking bench for axi_slave_write_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_slave_write_ctrl;

    localparam int IDS_W  = 8;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int LEN_W  = 4;
    localparam int MEM_AW = 14;
    localparam int TMO    = 20;

    logic                ACLK = 1'b0;
    logic                ARESETn = 1'b0;
    logic [IDS_W-1:0]    AWID = '0;
    logic [ADDR_W-1:0]   AWADDR = '0;
    logic [LEN_W-1:0]    AWLEN = '0;
    logic [2:0]          AWSIZE = '0;
    logic [1:0]          AWBURST = '0;
    logic                AWVALID = 1'b0;
    logic                AWREADY;
    logic [DATA_W-1:0]   WDATA = '0;
    logic [DATA_W/8-1:0] WSTRB = '0;
    logic                WLAST = 1'b0;
    logic                WVALID = 1'b0;
    logic                WREADY;
    logic [IDS_W-1:0]    BID;
    logic [1:0]          BRESP;
    logic                BVALID;
    logic                BREADY = 1'b0;
    logic                mem_we;
    logic [MEM_AW-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_wdata;
    logic [DATA_W/8-1:0] mem_bwe;

    int n_checks = 0;
    int n_fail   = 0;

    axi_slave_write_ctrl #(
        .IDS_W(IDS_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .MEM_AW(MEM_AW)
    ) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_bwe(mem_bwe)
    );

    always #5 ACLK = ~ACLK;

    // Stimulus drivers: inputs change 1ns after posedge, outputs sampled at negedge.
    task automatic drive_aw(input logic [7:0] id, input logic [31:0] addr,
                            input logic [3:0] len, input logic [2:0] size,
                            input logic [1:0] burst);
        int n = 0;
        AWID = id; AWADDR = addr; AWLEN = len; AWSIZE = size; AWBURST = burst;
        AWVALID = 1'b1;
        @(negedge ACLK);
        while (!AWREADY && n < TMO) begin
            @(posedge ACLK); #1; @(negedge ACLK); n++;
        end
        n_checks++;
        if (n >= TMO) begin
            n_fail++; $display("FAIL aw_timeout: AWREADY=%0b required 1", AWREADY);
        end
        @(posedge ACLK); #1;
        AWVALID = 1'b0;
    endtask

    task automatic drive_beat(input logic [31:0] data, input logic [3:0] strb,
                              input logic last, output logic we,
                              output logic [13:0] addr, output logic [3:0] bwe,
                              output logic [31:0] wd);
        int n = 0;
        WDATA = data; WSTRB = strb; WLAST = last; WVALID = 1'b1;
        @(negedge ACLK);
        while (!WREADY && n < TMO) begin
            @(posedge ACLK); #1; @(negedge ACLK); n++;
        end
        n_checks++;
        if (n >= TMO) begin
            n_fail++; $display("FAIL w_timeout: WREADY=%0b required 1", WREADY);
        end
        we = mem_we; addr = mem_addr; bwe = mem_bwe; wd = mem_wdata;
        @(posedge ACLK); #1;
        WVALID = 1'b0; WLAST = 1'b0;
    endtask

    task automatic take_b(output logic [7:0] id, output logic [1:0] resp, output int waited);
        int n = 0;
        BREADY = 1'b1;
        @(negedge ACLK);
        while (!BVALID && n < TMO) begin
            @(posedge ACLK); #1; @(negedge ACLK); n++;
        end
        n_checks++;
        if (n >= TMO) begin
            n_fail++; $display("FAIL b_timeout: BVALID=%0b required 1", BVALID);
        end
        id = BID; resp = BRESP; waited = n;
        @(posedge ACLK); #1;
        BREADY = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge ACLK);
        n_checks++;
        if (AWREADY !== 1'b1 || WREADY !== 1'b0 || BVALID !== 1'b0) begin
            n_fail++; $display("FAIL reset_ready: AW/W/B=%b%b%b required 100", AWREADY, WREADY, BVALID);
        end
        n_checks++;
        if (BRESP !== 2'b00 || BID !== 8'h00) begin
            n_fail++; $display("FAIL reset_b: BID=%0h BRESP=%b required 0/00", BID, BRESP);
        end
        n_checks++;
        if (mem_we !== 1'b0 || mem_bwe !== 4'h0 || mem_addr !== 14'h0) begin
            n_fail++; $display("FAIL reset_mem: we=%b bwe=%h addr=%h required 0/0/0", mem_we, mem_bwe, mem_addr);
        end
        @(posedge ACLK); #1;
    endtask

    task automatic test_incr;
        logic we; logic [13:0] a; logic [3:0] be; logic [31:0] wd;
        logic [7:0] id; logic [1:0] rs; int w;
        drive_aw(8'h12, 32'h100, 4'd3, 3'b010, 2'b01);
        for (int i = 0; i < 4; i++) begin
            drive_beat(32'hCAFE_0000 + i, 4'hF, (i == 3), we, a, be, wd);
            n_checks++;
            if (we !== 1'b1 || a !== 14'h40 + i || be !== 4'hF || wd !== 32'hCAFE_0000 + i) begin
                n_fail++;
                $display("FAIL incr_beat%0d: we=%b addr=%h bwe=%h wd=%h required 1/%h/f/%h",
                         i, we, a, be, wd, 14'h40 + i, 32'hCAFE_0000 + i);
            end
        end
        take_b(id, rs, w);
        n_checks++;
        if (id !== 8'h12 || rs !== 2'b00 || w != 0) begin
            n_fail++; $display("FAIL incr_b: BID=%h BRESP=%b wait=%0d required 12/00/0", id, rs, w);
        end
    endtask

    task automatic test_fixed;
        logic we; logic [13:0] a; logic [3:0] be; logic [31:0] wd;
        logic [7:0] id; logic [1:0] rs; int w;
        drive_aw(8'h05, 32'h200, 4'd2, 3'b010, 2'b00);
        for (int i = 0; i < 3; i++) begin
            drive_beat(32'h1111 * (i + 1), 4'b0011, (i == 2), we, a, be, wd);
            n_checks++;
            if (we !== 1'b1 || a !== 14'h80 || be !== 4'b0011) begin
                n_fail++; $display("FAIL fixed_beat%0d: we=%b addr=%h bwe=%b required 1/80/0011", i, we, a, be);
            end
        end
        take_b(id, rs, w);
        n_checks++;
        if (id !== 8'h05 || rs !== 2'b00) begin
            n_fail++; $display("FAIL fixed_b: BID=%h BRESP=%b required 05/00", id, rs);
        end
    endtask

    task automatic test_bad_size;
        logic we; logic [13:0] a; logic [3:0] be; logic [31:0] wd;
        logic [7:0] id; logic [1:0] rs; int w;
        drive_aw(8'h21, 32'h300, 4'd1, 3'b001, 2'b01);
        for (int i = 0; i < 2; i++) begin
            drive_beat(32'hDEAD_0000 + i, 4'hF, (i == 1), we, a, be, wd);
            n_checks++;
            if (we !== 1'b0 || be !== 4'h0) begin
                n_fail++; $display("FAIL badsize_beat%0d: we=%b bwe=%h required 0/0", i, we, be);
            end
        end
        take_b(id, rs, w);
        n_checks++;
        if (id !== 8'h21 || rs !== 2'b10) begin
            n_fail++; $display("FAIL badsize_b: BID=%h BRESP=%b required 21/10", id, rs);
        end
    endtask

    task automatic test_wlast_and_wrap;
        logic we; logic [13:0] a; logic [3:0] be; logic [31:0] wd;
        logic [7:0] id; logic [1:0] rs; int w;
        drive_aw(8'h3C, 32'h400, 4'd3, 3'b010, 2'b01);
        for (int i = 0; i < 4; i++) begin
            drive_beat(32'h0, 4'hF, (i == 2), we, a, be, wd);
            if (i == 2) begin
                @(negedge ACLK);
                n_checks++;
                if (WREADY !== 1'b1 || BVALID !== 1'b0) begin
                    n_fail++; $display("FAIL early_wlast_cont: WREADY=%b BVALID=%b required 1/0", WREADY, BVALID);
                end
                @(posedge ACLK); #1;
            end
        end
        take_b(id, rs, w);
        n_checks++;
        if (id !== 8'h3C || rs !== 2'b10 || w != 0) begin
            n_fail++; $display("FAIL wlast_b: BID=%h BRESP=%b wait=%0d required 3c/10/0", id, rs, w);
        end
        drive_aw(8'h4D, 32'h0000_FFFC, 4'd1, 3'b010, 2'b01);
        drive_beat(32'hA, 4'hF, 1'b0, we, a, be, wd);
        n_checks++;
        if (we !== 1'b1 || a !== 14'h3FFF) begin
            n_fail++; $display("FAIL wrap_beat0: we=%b addr=%h required 1/3fff", we, a);
        end
        drive_beat(32'hB, 4'hF, 1'b1, we, a, be, wd);
        n_checks++;
        if (we !== 1'b1 || a !== 14'h0000) begin
            n_fail++; $display("FAIL wrap_beat1: we=%b addr=%h required 1/0", we, a);
        end
        take_b(id, rs, w);
        n_checks++;
        if (id !== 8'h4D || rs !== 2'b00) begin
            n_fail++; $display("FAIL wrap_b: BID=%h BRESP=%b required 4d/00", id, rs);
        end
    endtask

    task automatic test_bready_hold;
        logic we; logic [13:0] a; logic [3:0] be; logic [31:0] wd;
        logic [7:0] id; logic [1:0] rs; int w;
        drive_aw(8'h33, 32'h10, 4'd0, 3'b010, 2'b01);
        drive_beat(32'h5, 4'hF, 1'b1, we, a, be, wd);
        n_checks++;
        if (we !== 1'b1 || a !== 14'h4) begin
            n_fail++; $display("FAIL hold_beat: we=%b addr=%h required 1/4", we, a);
        end
        AWID = 8'h44; AWADDR = 32'h20; AWLEN = 4'd0; AWSIZE = 3'b010; AWBURST = 2'b01;
        AWVALID = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge ACLK);
            n_checks++;
            if (BVALID !== 1'b1 || BID !== 8'h33 || BRESP !== 2'b00 || AWREADY !== 1'b0) begin
                n_fail++;
                $display("FAIL hold_cyc%0d: BVALID=%b BID=%h BRESP=%b AWREADY=%b required 1/33/00/0",
                         i, BVALID, BID, BRESP, AWREADY);
            end
            @(posedge ACLK); #1;
        end
        BREADY = 1'b1;
        @(posedge ACLK); #1;
        BREADY = 1'b0;
        @(negedge ACLK);
        n_checks++;
        if (BVALID !== 1'b0 || AWREADY !== 1'b1) begin
            n_fail++; $display("FAIL hold_after_b: BVALID=%b AWREADY=%b required 0/1", BVALID, AWREADY);
        end
        @(posedge ACLK); #1;
        AWVALID = 1'b0;
        @(negedge ACLK);
        n_checks++;
        if (AWREADY !== 1'b0 || WREADY !== 1'b1) begin
            n_fail++; $display("FAIL hold_aw_taken: AWREADY=%b WREADY=%b required 0/1", AWREADY, WREADY);
        end
        @(posedge ACLK); #1;
        drive_beat(32'h6, 4'hF, 1'b1, we, a, be, wd);
        n_checks++;
        if (we !== 1'b1 || a !== 14'h8) begin
            n_fail++; $display("FAIL hold_second_beat: we=%b addr=%h required 1/8", we, a);
        end
        take_b(id, rs, w);
        n_checks++;
        if (id !== 8'h44 || rs !== 2'b00) begin
            n_fail++; $display("FAIL hold_second_b: BID=%h BRESP=%b required 44/00", id, rs);
        end
    endtask

    task automatic test_reset_mid;
        logic we; logic [13:0] a; logic [3:0] be; logic [31:0] wd;
        logic [7:0] id; logic [1:0] rs; int w;
        drive_aw(8'h77, 32'h500, 4'd3, 3'b010, 2'b01);
        drive_beat(32'h1, 4'hF, 1'b0, we, a, be, wd);
        WDATA = 32'h2; WSTRB = 4'hF; WVALID = 1'b1;
        @(negedge ACLK);
        n_checks++;
        if (mem_we !== 1'b1 || mem_addr !== 14'h141) begin
            n_fail++; $display("FAIL rstmid_pre: we=%b addr=%h required 1/141", mem_we, mem_addr);
        end
        #1 ARESETn = 1'b0;
        #1;
        n_checks++;
        if (mem_we !== 1'b0 || WREADY !== 1'b0 || BVALID !== 1'b0 || AWREADY !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_async: we=%b WREADY=%b BVALID=%b AWREADY=%b required 0/0/0/1",
                     mem_we, WREADY, BVALID, AWREADY);
        end
        @(negedge ACLK);
        WVALID = 1'b0;
        ARESETn = 1'b1;
        @(posedge ACLK); #1;
        drive_aw(8'h78, 32'h40, 4'd0, 3'b010, 2'b01);
        drive_beat(32'h9, 4'hF, 1'b1, we, a, be, wd);
        n_checks++;
        if (we !== 1'b1 || a !== 14'h10) begin
            n_fail++; $display("FAIL rstmid_next_beat: we=%b addr=%h required 1/10", we, a);
        end
        take_b(id, rs, w);
        n_checks++;
        if (id !== 8'h78 || rs !== 2'b00) begin
            n_fail++; $display("FAIL rstmid_next_b: BID=%h BRESP=%b required 78/00", id, rs);
        end
    endtask

    initial begin
        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        ARESETn = 1'b1;
        @(posedge ACLK); #1;
        test_reset();
        test_incr();
        test_fixed();
        test_bad_size();
        test_wlast_and_wrap();
        test_bready_hold();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
